axi3_sys_bridge: RTL and testbench
==================================

// Module: axi3_sys_bridge
// PURPOSE
//  AXI3 slave that turns AXI bursts into single-beat system-bus accesses. It sits directly downstream of the AXI4->AXI3
//  interface adapter and drives the sys_* bus towards register/memory space. One transaction is in flight at a time.
//  Supported bursts: FIXED, INCR, WRAP.
// PARAMETERS
//  AXI_DW       64         data width (bits)
//  AXI_AW       32         address width
//  AXI_IW       8          ID width
//  AXI_SW       AXI_DW/8   strobe width
//  ACK_TIMEOUT  255        cycles to wait for sys ack/err; used only with AXI_SYS_TIMEOUT_EN
// PORTS
//  axi_clk_i      in   1       clock
//  axi_rstn_i     in   1       asynchronous active-low reset
//  axi_awid_i/awaddr_i/awlen_i/awsize_i/awburst_i  in  IW/AW/4/3/2   write address
//  axi_awlock_i/awcache_i/awprot_i                 in  2/4/3         accepted, ignored
//  axi_awvalid_i  in   1       write address valid
//  axi_awready_o  out  1       write address ready
//  axi_wid_i      in   IW      ignored; no write interleaving
//  axi_wdata_i/wstrb_i/wlast_i/wvalid_i            in  DW/SW/1/1     write data
//  axi_wready_o   out  1       write data ready
//  axi_bid_o/bresp_o/bvalid_o                      out IW/2/1        write response
//  axi_bready_i   in   1       write response ready
//  axi_arid_i/araddr_i/arlen_i/arsize_i/arburst_i  in  IW/AW/4/3/2   read address
//  axi_arlock_i/arcache_i/arprot_i                 in  2/4/3         accepted, ignored
//  axi_arvalid_i  in   1       read address valid
//  axi_arready_o  out  1       read address ready
//  axi_rid_o/rdata_o/rresp_o/rlast_o/rvalid_o      out IW/DW/2/1/1   read data
//  axi_rready_i   in   1       read data ready
//  sys_addr_o     out  AW      access address, byte address of the current beat
//  sys_wdata_o    out  DW      write data
//  sys_sel_o      out  SW      byte select: WSTRB on write, all ones on read
//  sys_wen_o      out  1       write strobe, 1-cycle pulse
//  sys_ren_o      out  1       read strobe, 1-cycle pulse
//  sys_rdata_i    in   DW      read data, sampled with ack
//  sys_err_i      in   1       access error
//  sys_ack_i      in   1       access done (may be tied high)
// BEHAVIOUR
//  - Reset: all outputs 0 (readies, valids, strobes, addr/wdata/sel, resp, rdata, rlast, ids). Reset mid-burst
//    aborts the burst silently; no response is issued.
//  - FSM states: IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA.
//  - IDLE: arbitration between AWVALID and ARVALID.
//    - If both are requesting, round-robin on the last granted direction; the reset value favours write.
//    - awready_o / arready_o = 1 only in IDLE for the granted side.
//    - On handshake, latch id, addr, len, size, burst; clear err flag and beat count. Then go to WR_DATA or RD_REQ.
//  - WR_DATA: wready_o = 1. On handshake, latch wdata/wstrb, then go to WR_REQ.
//  - WR_REQ: 1 cycle; sys_wen_o = 1 with addr/wdata/sel held stable. Ack/err in this cycle is ignored.
//  - WR_WAIT: addr/wdata/sel held until sys_ack_i | sys_err_i. An err sets a sticky err flag.
//    Then WR_RESP if beat == len, else advance address and go to WR_DATA.
//  - WLAST is not used for sequencing. WLAST != (beat == len) sets the err flag.
//  - WR_RESP: bvalid_o = 1, bid_o = latched ID, bresp_o = err ? 2'b10 : 2'b00. Held until bready_i, then IDLE.
//  - RD_REQ: 1 cycle; sys_ren_o = 1.
//  - RD_WAIT: on ack/err, register rdata <= sys_rdata_i (0 on err), rresp <= 10/00, then go to RD_DATA.
//  - RD_DATA: rvalid_o = 1, rid_o = latched ID, rlast_o = (beat == len). All held until rready_i.
//    Then IDLE if last, else advance address and go to RD_REQ.
//  - Address advance:
//    - FIXED: unchanged.
//    - INCR: aligned(addr) + (1 << size), mod 2^AW; 4KB crossing is not checked.
//    - WRAP: wraps inside the (len+1) << size aligned window.
//    - Beats after the first are aligned to size.
//  - Minimum latency per beat: write handshake -> strobe +1 cycle; ack earliest +2 cycles.
//    Read: AR handshake -> ren +1 cycle; rvalid at +3 cycles with ack tied high.
//  - Simultaneous ack and err count as err.
// CONFIGURATION
//  - AXI_SYS_TIMEOUT_EN defined: a counter runs in WR_WAIT/RD_WAIT. After ACK_TIMEOUT cycles without ack/err the access
//    completes as an error (SLVERR, rdata 0). The counter clears on every strobe.
//  - Not defined: WAIT states wait indefinitely; no counter logic.
// TESTING
//  1. Write: AW addr 0x40, len 0, size 3, INCR, id 5; W 0x1122334455667788 strb 0xFF; ack 2 cycles after wen
//     -> one wen, addr 0x40, sel 0xFF; B id 5, resp 00.
//  2. Read: INCR len 3, size 3, addr 0x100, ack tied 1 -> sys addr 0x100/108/110/118; 4 R beats, rlast only on 4th,
//     resp 00. Hold rready low 5 cycles on beat 2 -> rdata/rvalid stable, no extra ren.
//  3. Read: WRAP len 3, size 3, addr 0x18 -> sys addr 0x18, 0x00, 0x08, 0x10.
//  4. Write: len 1, sys_err_i on beat 2 -> both beats issued; bresp 2'b10. Early WLAST on beat 1 -> bresp 2'b10.
//  5. AWVALID and ARVALID both high after reset -> write served first, then read; repeat -> directions alternate.
//     Reset asserted mid-burst -> all outputs 0, next burst completes normally.
//  6. ack/err never asserted: with AXI_SYS_TIMEOUT_EN -> R beat at 255 cycles, resp 10, rdata 0; without the macro
//     -> rvalid stays 0 for 1000 cycles.

Source files
------------

// File: rtl/axi3_sys_bridge.sv
// AXI3 slave that converts FIXED/INCR/WRAP bursts into single-beat sys-bus accesses, one transaction at a time.
// Optional define AXI_SYS_TIMEOUT_EN: a missing sys ack/err completes as SLVERR after ACK_TIMEOUT wait cycles.
//
// state   | meaning
// IDLE    | arbitrate AW/AR, raise ready for the granted side
// WR_DATA | wready high, wait for a W beat
// WR_REQ  | one-cycle sys_wen pulse
// WR_WAIT | hold addr/wdata/sel until ack or err
// WR_RESP | bvalid high until bready
// RD_REQ  | one-cycle sys_ren pulse
// RD_WAIT | wait for ack or err, capture read data
// RD_DATA | rvalid high until rready
module axi3_sys_bridge #(
    parameter int AXI_DW      = 64,
    parameter int AXI_AW      = 32,
    parameter int AXI_IW      = 8,
    parameter int AXI_SW      = AXI_DW/8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              axi_clk_i,
    input  logic              axi_rstn_i,
    input  logic [AXI_IW-1:0] axi_awid_i,
    input  logic [AXI_AW-1:0] axi_awaddr_i,
    input  logic [3:0]        axi_awlen_i,
    input  logic [2:0]        axi_awsize_i,
    input  logic [1:0]        axi_awburst_i,
    input  logic [1:0]        axi_awlock_i,
    input  logic [3:0]        axi_awcache_i,
    input  logic [2:0]        axi_awprot_i,
    input  logic              axi_awvalid_i,
    output logic              axi_awready_o,
    input  logic [AXI_IW-1:0] axi_wid_i,
    input  logic [AXI_DW-1:0] axi_wdata_i,
    input  logic [AXI_SW-1:0] axi_wstrb_i,
    input  logic              axi_wlast_i,
    input  logic              axi_wvalid_i,
    output logic              axi_wready_o,
    output logic [AXI_IW-1:0] axi_bid_o,
    output logic [1:0]        axi_bresp_o,
    output logic              axi_bvalid_o,
    input  logic              axi_bready_i,
    input  logic [AXI_IW-1:0] axi_arid_i,
    input  logic [AXI_AW-1:0] axi_araddr_i,
    input  logic [3:0]        axi_arlen_i,
    input  logic [2:0]        axi_arsize_i,
    input  logic [1:0]        axi_arburst_i,
    input  logic [1:0]        axi_arlock_i,
    input  logic [3:0]        axi_arcache_i,
    input  logic [2:0]        axi_arprot_i,
    input  logic              axi_arvalid_i,
    output logic              axi_arready_o,
    output logic [AXI_IW-1:0] axi_rid_o,
    output logic [AXI_DW-1:0] axi_rdata_o,
    output logic [1:0]        axi_rresp_o,
    output logic              axi_rlast_o,
    output logic              axi_rvalid_o,
    input  logic              axi_rready_i,
    output logic [AXI_AW-1:0] sys_addr_o,
    output logic [AXI_DW-1:0] sys_wdata_o,
    output logic [AXI_SW-1:0] sys_sel_o,
    output logic              sys_wen_o,
    output logic              sys_ren_o,
    input  logic [AXI_DW-1:0] sys_rdata_i,
    input  logic              sys_err_i,
    input  logic              sys_ack_i
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_DATA
    } state_t;

    localparam logic [AXI_AW-1:0] A_ONE = AXI_AW'(1);

    state_t            state;
    logic [AXI_IW-1:0] id_q;
    logic [3:0]        len_q;
    logic [3:0]        beat_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q;
    logic              last_wr_q;
    logic              last_beat;
    logic              sys_done;
    logic              sys_fail;
    logic [AXI_AW-1:0] incr;
    logic [AXI_AW-1:0] aligned;
    logic [AXI_AW-1:0] wrap_mask;
    logic [AXI_AW-1:0] next_addr;
    logic              unused_inputs;

    assign unused_inputs = ^{axi_awlock_i, axi_awcache_i, axi_awprot_i,
                             axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_wid_i};

    assign last_beat = (beat_q == len_q);

`ifdef AXI_SYS_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Reloaded on every strobe, counts down only while waiting for the sys side.
    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            tmo_cnt <= '0;
        end else if (state == WR_REQ || state == RD_REQ) begin
            tmo_cnt <= TW'(ACK_TIMEOUT - 1);
        end else if ((state == WR_WAIT || state == RD_WAIT) && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    assign tmo_hit  = (tmo_cnt == '0);
    assign sys_done = sys_ack_i | sys_err_i | tmo_hit;
    assign sys_fail = sys_err_i | (tmo_hit & ~sys_ack_i);
`else
    localparam int unused_ack_timeout = ACK_TIMEOUT;

    assign sys_done = sys_ack_i | sys_err_i;
    assign sys_fail = sys_err_i;
`endif

    // WRAP keeps the upper address bits and wraps the low bits inside the (len+1)<<size window.
    always_comb begin
        incr      = A_ONE << size_q;
        aligned   = sys_addr_o & ~(incr - A_ONE);
        wrap_mask = ((AXI_AW'(len_q) + A_ONE) << size_q) - A_ONE;
        next_addr = sys_addr_o;
        case (burst_q)
            2'b01:   next_addr = aligned + incr;
            2'b10:   next_addr = (sys_addr_o & ~wrap_mask) | ((aligned + incr) & wrap_mask);
            default: next_addr = sys_addr_o;
        endcase
    end

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            state         <= IDLE;
            id_q          <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            err_q         <= 1'b0;
            last_wr_q     <= 1'b0;
            axi_awready_o <= 1'b0;
            axi_arready_o <= 1'b0;
            axi_wready_o  <= 1'b0;
            axi_bid_o     <= '0;
            axi_bresp_o   <= '0;
            axi_bvalid_o  <= 1'b0;
            axi_rid_o     <= '0;
            axi_rdata_o   <= '0;
            axi_rresp_o   <= '0;
            axi_rlast_o   <= 1'b0;
            axi_rvalid_o  <= 1'b0;
            sys_addr_o    <= '0;
            sys_wdata_o   <= '0;
            sys_sel_o     <= '0;
            sys_wen_o     <= 1'b0;
            sys_ren_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (axi_awready_o && axi_awvalid_i) begin
                        axi_awready_o <= 1'b0;
                        id_q          <= axi_awid_i;
                        sys_addr_o    <= axi_awaddr_i;
                        len_q         <= axi_awlen_i;
                        size_q        <= axi_awsize_i;
                        burst_q       <= axi_awburst_i;
                        err_q         <= 1'b0;
                        beat_q        <= '0;
                        last_wr_q     <= 1'b1;
                        axi_wready_o  <= 1'b1;
                        state         <= WR_DATA;
                    end else if (axi_arready_o && axi_arvalid_i) begin
                        axi_arready_o <= 1'b0;
                        id_q          <= axi_arid_i;
                        sys_addr_o    <= axi_araddr_i;
                        len_q         <= axi_arlen_i;
                        size_q        <= axi_arsize_i;
                        burst_q       <= axi_arburst_i;
                        err_q         <= 1'b0;
                        beat_q        <= '0;
                        last_wr_q     <= 1'b0;
                        sys_sel_o     <= '1;
                        sys_ren_o     <= 1'b1;
                        state         <= RD_REQ;
                    end else if (!axi_awready_o && !axi_arready_o) begin
                        // Contention goes to the direction not served last time.
                        if (axi_awvalid_i && (!axi_arvalid_i || !last_wr_q)) begin
                            axi_awready_o <= 1'b1;
                        end else if (axi_arvalid_i) begin
                            axi_arready_o <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (axi_wvalid_i) begin
                        axi_wready_o <= 1'b0;
                        sys_wdata_o  <= axi_wdata_i;
                        sys_sel_o    <= axi_wstrb_i;
                        sys_wen_o    <= 1'b1;
                        if (axi_wlast_i != last_beat) begin
                            err_q <= 1'b1;
                        end
                        state <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    sys_wen_o <= 1'b0;
                    state     <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (sys_done) begin
                        if (sys_fail) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            axi_bvalid_o <= 1'b1;
                            axi_bid_o    <= id_q;
                            axi_bresp_o  <= (err_q | sys_fail) ? 2'b10 : 2'b00;
                            state        <= WR_RESP;
                        end else begin
                            sys_addr_o   <= next_addr;
                            beat_q       <= beat_q + 4'd1;
                            axi_wready_o <= 1'b1;
                            state        <= WR_DATA;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_bready_i) begin
                        axi_bvalid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RD_REQ: begin
                    sys_ren_o <= 1'b0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (sys_done) begin
                        axi_rdata_o  <= sys_fail ? '0 : sys_rdata_i;
                        axi_rresp_o  <= sys_fail ? 2'b10 : 2'b00;
                        axi_rid_o    <= id_q;
                        axi_rlast_o  <= last_beat;
                        axi_rvalid_o <= 1'b1;
                        state        <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_rready_i) begin
                        axi_rvalid_o <= 1'b0;
                        axi_rlast_o  <= 1'b0;
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            sys_addr_o <= next_addr;
                            beat_q     <= beat_q + 4'd1;
                            sys_ren_o  <= 1'b1;
                            state      <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_sys_bridge.sv
// Directed self-checking bench for axi3_sys_bridge: bursts, arbitration, errors, reset abort, missing ack.
// Honours AXI_SYS_TIMEOUT_EN for the missing-ack scenario.
module tb_axi3_sys_bridge;

    logic        clk;
    logic        rst_n;
    logic [7:0]  awid, arid, wid, bid, rid;
    logic [31:0] awaddr, araddr, sys_addr;
    logic [3:0]  awlen, arlen, awcache, arcache;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [63:0] wdata, rdata, sys_wdata, sys_rdata;
    logic [7:0]  wstrb, sys_sel;
    logic        wlast, wvalid, wready, bvalid, bready;
    logic        rlast, rvalid, rready;
    logic        sys_wen, sys_ren, sys_err, sys_ack;

    int total = 0;
    int bad = 0;

    // sys responder: 0 = ack tied high, 1 = ack two cycles after each strobe, 2 = never answer
    int ack_mode = 0;
    int err_idx = -1;
    int n_strb;
    int ack_cnt;
    bit err_pend;
    logic [31:0] log_addr [256];
    logic [7:0]  log_sel [256];
    logic [63:0] log_wdata [256];
    logic        log_wr [256];

    assign sys_rdata = {sys_addr, ~sys_addr};

    axi3_sys_bridge dut (
        .axi_clk_i(clk), .axi_rstn_i(rst_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awlock_i(awlock), .axi_awcache_i(awcache), .axi_awprot_i(awprot),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wid_i(wid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arlock_i(arlock), .axi_arcache_i(arcache), .axi_arprot_i(arprot),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .sys_addr_o(sys_addr), .sys_wdata_o(sys_wdata), .sys_sel_o(sys_sel),
        .sys_wen_o(sys_wen), .sys_ren_o(sys_ren), .sys_rdata_i(sys_rdata),
        .sys_err_i(sys_err), .sys_ack_i(sys_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        n_strb   = 0;
        ack_cnt  = 0;
        err_pend = 1'b0;
        sys_ack  = 1'b0;
        sys_err  = 1'b0;
        forever begin
            @(negedge clk);
            sys_ack = (ack_mode == 0);
            sys_err = 1'b0;
            if (ack_cnt != 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    if (err_pend) sys_err = 1'b1;
                    else          sys_ack = 1'b1;
                end
            end
            if (sys_wen || sys_ren) begin
                log_addr[n_strb % 256]  = sys_addr;
                log_sel[n_strb % 256]   = sys_sel;
                log_wdata[n_strb % 256] = sys_wdata;
                log_wr[n_strb % 256]    = sys_wen;
                n_strb++;
                err_pend = (n_strb == err_idx);
                if (ack_mode == 1) ack_cnt = 2;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_rdata(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic drive_idle();
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_wready"}, wready, 0);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_bid_bresp"}, {bid, bresp}, 0);
        check({tag, "_rvalid_rlast"}, {rvalid, rlast}, 0);
        check({tag, "_rid_rresp"}, {rid, rresp}, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_sys_addr"}, sys_addr, 0);
        check({tag, "_sys_wdata"}, sys_wdata, 0);
        check({tag, "_sys_sel"}, sys_sel, 0);
        check({tag, "_sys_strobes"}, {sys_wen, sys_ren}, 0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        check_outputs_zero(tag);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic aw_send(input string tag, input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        do begin @(negedge clk); k++; end while (!awready && k < 50);
        check({tag, "_awready"}, awready, 1);
        @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic ar_send(input string tag, input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        do begin @(negedge clk); k++; end while (!arready && k < 50);
        check({tag, "_arready"}, arready, 1);
        @(posedge clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic w_send(input string tag, input logic [63:0] d, input logic [7:0] s, input logic l);
        int k = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        do begin @(negedge clk); k++; end while (!wready && k < 50);
        check({tag, "_wready"}, wready, 1);
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [7:0] exp_id, input logic [1:0] exp_resp);
        int k = 0;
        do begin @(negedge clk); k++; end while (!bvalid && k < 50);
        check({tag, "_bvalid"}, bvalid, 1);
        check({tag, "_bid"}, bid, exp_id);
        check({tag, "_bresp"}, bresp, exp_resp);
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [7:0] exp_id, input logic [63:0] exp_data,
                          input logic exp_last, input logic [1:0] exp_resp, input int hold);
        int k = 0;
        int s0;
        bit stable;
        logic [63:0] d0;
        do begin @(negedge clk); k++; end while (!rvalid && k < 50);
        check({tag, "_rvalid"}, rvalid, 1);
        check({tag, "_rid"}, rid, exp_id);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, rresp, exp_resp);
        check({tag, "_rlast"}, rlast, exp_last);
        if (hold > 0) begin
            d0 = rdata;
            s0 = n_strb;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!rvalid || rdata !== d0) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, stable, 1);
            check({tag, "_hold_no_ren"}, n_strb - s0, 0);
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic check_strobe(input string tag, input int idx, input logic exp_wr,
                                input logic [31:0] exp_addr, input logic [7:0] exp_sel);
        check({tag, "_kind"}, log_wr[idx % 256], exp_wr);
        check({tag, "_addr"}, log_addr[idx % 256], exp_addr);
        check({tag, "_sel"}, log_sel[idx % 256], exp_sel);
    endtask

    logic [31:0] wrap_addrs [4];
    int base;
    int k;
    int seen;

    initial begin
        rst_n = 1'b0;
        drive_idle();
        wrap_addrs[0] = 32'h18; wrap_addrs[1] = 32'h00; wrap_addrs[2] = 32'h08; wrap_addrs[3] = 32'h10;

        apply_reset("reset");

        // single-beat write, delayed ack
        ack_mode = 1;
        base = n_strb;
        aw_send("wr1", 8'h05, 32'h40, 4'd0, 3'd3, 2'b01);
        w_send("wr1", 64'h1122334455667788, 8'hFF, 1'b1);
        b_recv("wr1", 8'h05, 2'b00);
        check("wr1_nstrb", n_strb - base, 1);
        check_strobe("wr1_s0", base, 1'b1, 32'h40, 8'hFF);
        check("wr1_wdata", log_wdata[base % 256], 64'h1122334455667788);

        // INCR read with ack tied high, stall on beat 2
        ack_mode = 0;
        base = n_strb;
        ar_send("rd_incr", 8'h03, 32'h100, 4'd3, 3'd3, 2'b01);
        r_recv("rd_incr_b0", 8'h03, 64'h00000100_FFFFFEFF, 1'b0, 2'b00, 0);
        r_recv("rd_incr_b1", 8'h03, 64'h00000108_FFFFFEF7, 1'b0, 2'b00, 5);
        r_recv("rd_incr_b2", 8'h03, 64'h00000110_FFFFFEEF, 1'b0, 2'b00, 0);
        r_recv("rd_incr_b3", 8'h03, 64'h00000118_FFFFFEE7, 1'b1, 2'b00, 0);
        check("rd_incr_nstrb", n_strb - base, 4);
        check_strobe("rd_incr_s0", base,     1'b0, 32'h100, 8'hFF);
        check_strobe("rd_incr_s1", base + 1, 1'b0, 32'h108, 8'hFF);
        check_strobe("rd_incr_s2", base + 2, 1'b0, 32'h110, 8'hFF);
        check_strobe("rd_incr_s3", base + 3, 1'b0, 32'h118, 8'hFF);

        // WRAP read
        base = n_strb;
        ar_send("rd_wrap", 8'h0C, 32'h18, 4'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            r_recv($sformatf("rd_wrap_b%0d", i), 8'h0C, model_rdata(wrap_addrs[i]), (i == 3), 2'b00, 0);
        end
        check("rd_wrap_nstrb", n_strb - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_wrap_addr%0d", i), log_addr[(base + i) % 256], wrap_addrs[i]);
        end

        // write with sys error on beat 2
        ack_mode = 1;
        base = n_strb;
        err_idx = base + 2;
        aw_send("wr_err", 8'h07, 32'h200, 4'd1, 3'd3, 2'b01);
        w_send("wr_err_b0", 64'hAAAA0000BBBB0000, 8'h0F, 1'b0);
        w_send("wr_err_b1", 64'hCCCC0000DDDD0000, 8'hF0, 1'b1);
        b_recv("wr_err", 8'h07, 2'b10);
        err_idx = -1;
        check("wr_err_nstrb", n_strb - base, 2);
        check_strobe("wr_err_s0", base,     1'b1, 32'h200, 8'h0F);
        check_strobe("wr_err_s1", base + 1, 1'b1, 32'h208, 8'hF0);

        // early WLAST on beat 1
        base = n_strb;
        aw_send("wr_wlast", 8'h08, 32'h300, 4'd1, 3'd3, 2'b01);
        w_send("wr_wlast_b0", 64'h1, 8'hFF, 1'b1);
        w_send("wr_wlast_b1", 64'h2, 8'hFF, 1'b1);
        b_recv("wr_wlast", 8'h08, 2'b10);
        check("wr_wlast_nstrb", n_strb - base, 2);

        // arbitration: write wins after reset
        apply_reset("reset2");
        awid = 8'h01; awaddr = 32'h500; awlen = 4'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        arid = 8'h02; araddr = 32'h600; arlen = 4'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && !arready && k < 50);
        check("arb1_grant", {awready, arready}, 2'b10);
        @(posedge clk);
        #1 awvalid = 1'b0;
        w_send("arb1_w", 64'h5, 8'hFF, 1'b1);
        b_recv("arb1_w", 8'h01, 2'b00);
        k = 0;
        do begin @(negedge clk); k++; end while (!arready && k < 50);
        check("arb1_arready", arready, 1);
        @(posedge clk);
        #1 arvalid = 1'b0;
        r_recv("arb1_r", 8'h02, model_rdata(32'h600), 1'b1, 2'b00, 0);

        // after a lone write, contention goes to the read
        aw_send("arb2_lone", 8'h03, 32'h508, 4'd0, 3'd3, 2'b01);
        w_send("arb2_lone", 64'h6, 8'hFF, 1'b1);
        b_recv("arb2_lone", 8'h03, 2'b00);
        awid = 8'h04; awaddr = 32'h510; awvalid = 1'b1;
        arid = 8'h05; araddr = 32'h608; arvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && !arready && k < 50);
        check("arb2_grant", {awready, arready}, 2'b01);
        @(posedge clk);
        #1 arvalid = 1'b0;
        r_recv("arb2_r", 8'h05, model_rdata(32'h608), 1'b1, 2'b00, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 50);
        check("arb2_awready", awready, 1);
        @(posedge clk);
        #1 awvalid = 1'b0;
        w_send("arb2_w", 64'h7, 8'hFF, 1'b1);
        b_recv("arb2_w", 8'h04, 2'b00);

        // reset in the middle of a read burst
        ack_mode = 0;
        ar_send("rst_mid", 8'h09, 32'h400, 4'd3, 3'd3, 2'b01);
        r_recv("rst_mid_b0", 8'h09, model_rdata(32'h400), 1'b0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        ack_mode = 1;
        aw_send("post_rst", 8'h0A, 32'h80, 4'd0, 3'd3, 2'b01);
        w_send("post_rst", 64'hDEADBEEF, 8'h0F, 1'b1);
        b_recv("post_rst", 8'h0A, 2'b00);

        // sys side never answers
        ack_mode = 2;
        base = n_strb;
        ar_send("no_ack", 8'h0B, 32'h700, 4'd0, 3'd3, 2'b01);
`ifdef AXI_SYS_TIMEOUT_EN
        k = 0;
        do begin @(negedge clk); k++; end while (!rvalid && k < 400);
        check("tmo_window", (k >= 250 && k <= 262), 1);
        check("tmo_rvalid", rvalid, 1);
        check("tmo_rresp", rresp, 2'b10);
        check("tmo_rdata", rdata, 64'h0);
        check("tmo_rlast", rlast, 1);
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
`else
        seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (rvalid) seen++;
        end
        check("no_ack_rvalid", seen, 0);
`endif
        check("no_ack_nstrb", n_strb - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
